// File: rtl/gpr_arb_pkg.sv
// Shared widths, arbiter state encoding and scoreboard helpers for the GPR write arbiter.
// Optional bypass feature in the top level is selected with GPR_ARB_BYPASS_EN.
package gpr_arb_pkg;

    localparam int REG_ADDR_W        = 5;
    localparam int DATA_W            = 32;
    localparam int NUM_REGS          = 32;
    localparam int STARVE_LIMIT_DEF  = 4;
    localparam int STARVE_CNT_W      = 4;

    typedef enum logic [0:0] {
        PRIO0  = 1'b0,
        FORCE1 = 1'b1
    } arb_state_e;

    // One-hot decode of a register address into a busy-mask position.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask_v;
        mask_v       = {NUM_REGS{1'b0}};
        mask_v[addr] = 1'b1;
        return mask_v;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write busy mask with combinational hazard lookup for two read ports.
// With GPR_ARB_BYPASS_EN defined, hazards are masked by a same-cycle writeback match.
module gpr_scoreboard
    import gpr_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rsv_en,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    input  logic                  regWr,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [REG_ADDR_W-1:0] Rs,
    input  logic [REG_ADDR_W-1:0] Rt,
`ifdef GPR_ARB_BYPASS_EN
    output logic                  byp_hitA,
    output logic                  byp_hitB,
`endif
    output logic                  hazA,
    output logic                  hazB
);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_next_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic                byp_a_s;
    logic                byp_b_s;

    // Set/clear masks; reserve is applied after clear so it wins a collision.
    always_comb begin
        set_mask_s  = {NUM_REGS{1'b0}};
        clr_mask_s  = {NUM_REGS{1'b0}};
        if (rsv_en && (rsv_addr != 5'd0)) begin
            set_mask_s = addr_onehot(rsv_addr);
        end else begin
            set_mask_s = {NUM_REGS{1'b0}};
        end
        if (regWr) begin
            clr_mask_s = addr_onehot(wr_addr);
        end else begin
            clr_mask_s = {NUM_REGS{1'b0}};
        end
        busy_next_s    = (busy_r & ~clr_mask_s) | set_mask_s;
        busy_next_s[0] = 1'b0;
    end

    // Busy mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Hazard lookup, optionally masked by a writeback that is forwarding this cycle.
    always_comb begin
        byp_a_s = 1'b0;
        byp_b_s = 1'b0;
`ifdef GPR_ARB_BYPASS_EN
        byp_a_s = regWr && (wr_addr == Rs) && (Rs != 5'd0);
        byp_b_s = regWr && (wr_addr == Rt) && (Rt != 5'd0);
`endif
        hazA = busy_r[Rs] && !byp_a_s;
        hazB = busy_r[Rt] && !byp_b_s;
    end

`ifdef GPR_ARB_BYPASS_EN
    assign byp_hitA = byp_a_s;
    assign byp_hitB = byp_b_s;
`endif

endmodule

// File: rtl/gpr_write_arbiter.sv
// Two-requester register-file write arbiter with starvation guard and pending-write scoreboard.
// Define GPR_ARB_BYPASS_EN to add byp_hitA/byp_hitB and bypass-masked hazards.
module gpr_write_arbiter
    import gpr_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [REG_ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [REG_ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_data,
    output logic                  regWr,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     busW,
    input  logic                  rsv_en,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    input  logic [REG_ADDR_W-1:0] Rs,
    input  logic [REG_ADDR_W-1:0] Rt,
`ifdef GPR_ARB_BYPASS_EN
    output logic                  byp_hitA,
    output logic                  byp_hitB,
`endif
    output logic                  hazA,
    output logic                  hazB
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_e                state_r;
    arb_state_e                state_next_s;
    logic [STARVE_CNT_W-1:0]   cnt_r;
    logic [STARVE_CNT_W-1:0]   cnt_next_s;
    logic                      acc0_s;
    logic                      acc1_s;
    logic                      regwr_r;
    logic [REG_ADDR_W-1:0]     wr_addr_r;
    logic [DATA_W-1:0]         busw_r;

    // Ready generation; both readies are held low while reset is asserted.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (reset) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end else begin
            case (state_r)
                PRIO0: begin
                    req0_ready = 1'b1;
                    req1_ready = !req0_valid;
                end
                FORCE1: begin
                    req0_ready = 1'b0;
                    req1_ready = 1'b1;
                end
                default: begin
                    req0_ready = 1'b0;
                    req1_ready = 1'b0;
                end
            endcase
        end
    end

    assign acc0_s = req0_valid && req0_ready;
    assign acc1_s = req1_valid && req1_ready;

    // Starvation counter next value and arbitration state transitions.
    always_comb begin
        cnt_next_s   = {STARVE_CNT_W{1'b0}};
        state_next_s = state_r;
        if (req1_valid && !req1_ready) begin
            cnt_next_s = cnt_r + 4'd1;
        end else begin
            cnt_next_s = {STARVE_CNT_W{1'b0}};
        end
        case (state_r)
            PRIO0: begin
                if (cnt_next_s == LIMIT_C) begin
                    state_next_s = FORCE1;
                end else begin
                    state_next_s = PRIO0;
                end
            end
            FORCE1: begin
                if (acc1_s || !req1_valid) begin
                    state_next_s = PRIO0;
                end else begin
                    state_next_s = FORCE1;
                end
            end
            default: begin
                state_next_s = PRIO0;
            end
        endcase
    end

    // Arbitration state and starvation counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= PRIO0;
            cnt_r   <= {STARVE_CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Write port register; an accepted r0 write completes the handshake but never enables the file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwr_r   <= 1'b0;
            wr_addr_r <= {REG_ADDR_W{1'b0}};
            busw_r    <= {DATA_W{1'b0}};
        end else if (acc0_s) begin
            regwr_r   <= (req0_addr != 5'd0);
            wr_addr_r <= req0_addr;
            busw_r    <= req0_data;
        end else if (acc1_s) begin
            regwr_r   <= (req1_addr != 5'd0);
            wr_addr_r <= req1_addr;
            busw_r    <= req1_data;
        end else begin
            regwr_r   <= 1'b0;
            wr_addr_r <= wr_addr_r;
            busw_r    <= busw_r;
        end
    end

    assign regWr   = regwr_r;
    assign wr_addr = wr_addr_r;
    assign busW    = busw_r;

    gpr_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .regWr    (regwr_r),
        .wr_addr  (wr_addr_r),
        .Rs       (Rs),
        .Rt       (Rt),
`ifdef GPR_ARB_BYPASS_EN
        .byp_hitA (byp_hitA),
        .byp_hitB (byp_hitB),
`endif
        .hazA     (hazA),
        .hazB     (hazB)
    );

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed self-checking bench for gpr_write_arbiter (default STARVE_LIMIT = 4).
module tb_gpr_write_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        regWr;
    logic [4:0]  wr_addr;
    logic [31:0] busW;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic        hazA;
    logic        hazB;
`ifdef GPR_ARB_BYPASS_EN
    logic        byp_hitA;
    logic        byp_hitB;
`endif

    int checks;
    int failures;

    gpr_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .regWr      (regWr),
        .wr_addr    (wr_addr),
        .busW       (busW),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .Rs         (Rs),
        .Rt         (Rt),
`ifdef GPR_ARB_BYPASS_EN
        .byp_hitA   (byp_hitA),
        .byp_hitB   (byp_hitB),
`endif
        .hazA       (hazA),
        .hazB       (hazB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'd1;
        req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'd2;
        step(); step();
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        checks++; if (regWr !== 1'b0 || wr_addr !== 5'd0 || busW !== 32'd0) begin failures++; $display("FAIL reset_wr got=%b/%0d/%0d exp=0/0/0", regWr, wr_addr, busW); end
        checks++; if (hazA !== 1'b0 || hazB !== 1'b0) begin failures++; $display("FAIL reset_haz got=%b%b exp=00", hazA, hazB); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        step();
        checks++; if (regWr !== 1'b0) begin failures++; $display("FAIL post_reset_regwr got=%b exp=0", regWr); end
    endtask

    task automatic test_basic_write();
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'd80;
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if (regWr !== 1'b1 || wr_addr !== 5'd4 || busW !== 32'd80) begin failures++; $display("FAIL basic_write got=%b/%0d/%0d exp=1/4/80", regWr, wr_addr, busW); end
        step();
        checks++; if (regWr !== 1'b0 || wr_addr !== 5'd4 || busW !== 32'd80) begin failures++; $display("FAIL basic_hold got=%b/%0d/%0d exp=0/4/80", regWr, wr_addr, busW); end
    endtask

    task automatic test_starve();
        logic [5:0] exp_r0;
        logic [5:0] exp_r1;
        exp_r0 = 6'b101111;
        exp_r1 = 6'b010000;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'd111;
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'd7;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (req0_ready !== exp_r0[c] || req1_ready !== exp_r1[c]) begin failures++; $display("FAIL starve_ready cyc=%0d got=%b%b exp=%b%b", c + 1, req0_ready, req1_ready, exp_r0[c], exp_r1[c]); end
            step();
            if (c == 4) begin
                checks++; if (regWr !== 1'b1 || wr_addr !== 5'd5 || busW !== 32'd7) begin failures++; $display("FAIL starve_grant got=%b/%0d/%0d exp=1/5/7", regWr, wr_addr, busW); end
            end else begin
                checks++; if (regWr !== 1'b1 || wr_addr !== 5'd3 || busW !== 32'd111) begin failures++; $display("FAIL starve_r0 cyc=%0d got=%b/%0d/%0d exp=1/3/111", c + 1, regWr, wr_addr, busW); end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    task automatic test_addr0();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'd9;
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL addr0_ready got=%b exp=1", req1_ready); end
        step();
        req1_valid = 1'b0;
        checks++; if (regWr !== 1'b0) begin failures++; $display("FAIL addr0_regwr got=%b exp=0", regWr); end
    endtask

    task automatic test_hazard();
        rsv_en = 1'b1; rsv_addr = 5'd4; Rs = 5'd4; Rt = 5'd0;
        step();
        rsv_en = 1'b0;
        checks++; if (hazA !== 1'b1 || hazB !== 1'b0) begin failures++; $display("FAIL haz_set got=%b%b exp=10", hazA, hazB); end
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h1234;
        step();
        req0_valid = 1'b0;
`ifdef GPR_ARB_BYPASS_EN
        checks++; if (hazA !== 1'b0 || byp_hitA !== 1'b1) begin failures++; $display("FAIL haz_bypass got=%b/%b exp=0/1", hazA, byp_hitA); end
`else
        checks++; if (hazA !== 1'b1 || regWr !== 1'b1) begin failures++; $display("FAIL haz_wrcycle got=%b/%b exp=1/1", hazA, regWr); end
`endif
        step();
        checks++; if (hazA !== 1'b0) begin failures++; $display("FAIL haz_clear got=%b exp=0", hazA); end
    endtask

    task automatic test_reserve_collision();
        rsv_en = 1'b1; rsv_addr = 5'd6; Rt = 5'd6; Rs = 5'd0;
        step();
        rsv_en = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'd66;
        step();
        req0_valid = 1'b0;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        checks++; if (regWr !== 1'b1 || wr_addr !== 5'd6) begin failures++; $display("FAIL coll_wr got=%b/%0d exp=1/6", regWr, wr_addr); end
        step();
        rsv_en = 1'b0;
        checks++; if (hazB !== 1'b1 || hazA !== 1'b0) begin failures++; $display("FAIL coll_busy got=%b%b exp=01", hazA, hazB); end
        step();
        checks++; if (hazB !== 1'b1) begin failures++; $display("FAIL coll_hold got=%b exp=1", hazB); end
    endtask

    task automatic test_reset_midrun();
        rsv_en = 1'b1; rsv_addr = 5'd9; Rs = 5'd9;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hCAFE;
        step();
        rsv_en = 1'b0;
        checks++; if (regWr !== 1'b1 || hazA !== 1'b1 || hazB !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b/%b/%b exp=1/1/1", regWr, hazA, hazB); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (regWr !== 1'b0 || wr_addr !== 5'd0 || busW !== 32'd0) begin failures++; $display("FAIL mid_wr got=%b/%0d/%0d exp=0/0/0", regWr, wr_addr, busW); end
        checks++; if (hazA !== 1'b0 || hazB !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_clr got=%b%b%b%b exp=0000", hazA, hazB, req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        reset = 1'b0;
        step();
        checks++; if (regWr !== 1'b0 || hazA !== 1'b0) begin failures++; $display("FAIL mid_after got=%b/%b exp=0/0", regWr, hazA); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
        rsv_en = 1'b0; rsv_addr = 5'd0; Rs = 5'd0; Rt = 5'd0;
        test_reset();
        test_basic_write();
        test_starve();
        test_addr0();
        test_hazard();
        test_reserve_collision();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpr_write_arbiter.md
GPR_WRITE_ARBITER -- requirements
Module: gpr_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive blocked cycles of requester 1 before it is forced a grant; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  primary (pipeline writeback) write request.
REQ-005 req0_ready  output  1  requester 0 accepted this cycle when valid and ready are both high.
REQ-006 req0_addr  input  5  destination register of requester 0.
REQ-007 req0_data  input  32  write data of requester 0.
REQ-008 req1_valid, req1_ready, req1_addr, req1_data  in/out/in/in  1/1/5/32  secondary (multi-cycle unit) requester, same semantics as requester 0.
REQ-009 regWr  output  1  write enable to the register file.
REQ-010 wr_addr  output  5  register-file write address.
REQ-011 busW  output  32  register-file write data.
REQ-012 rsv_en  input  1  reserve (mark pending) register rsv_addr.
REQ-013 rsv_addr  input  5  register to reserve.
REQ-014 Rs, Rt  input  5 each  read addresses to check for hazards.
REQ-015 hazA, hazB  output  1 each  combinational: a pending write exists for Rs / Rt.

Function
REQ-016 States: PRIO0 (requester 0 has priority) and FORCE1 (requester 1 has priority); the arbiter SHALL accept at most one request per cycle.
REQ-017 In PRIO0: req0_ready = 1; req1_ready = !req0_valid.
REQ-018 In FORCE1: req1_ready = 1; req0_ready = 0.
REQ-019 Both readies SHALL be 0 while reset is high.
REQ-020 starve counter (4 bits) SHALL increment each cycle req1_valid && !req1_ready, and clear when requester 1 is accepted or req1_valid is low.
REQ-021 PRIO0 -> FORCE1 on the edge where the counter reaches STARVE_LIMIT; FORCE1 -> PRIO0 on the edge after a requester-1 acceptance, or when req1_valid is low.
REQ-022 An acceptance in cycle N SHALL drive regWr = 1, wr_addr, and busW from the accepted request in cycle N+1 (registered, 1-cycle latency); with no acceptance, regWr = 0 and wr_addr/busW hold.
REQ-023 A request with addr 0 SHALL complete the handshake normally, but regWr SHALL stay 0 in cycle N+1.
REQ-024 Scoreboard: 32-bit busy mask; rsv_en with a nonzero rsv_addr SHALL set busy[rsv_addr] on the edge; bit 0 is never set.
REQ-025 busy[wr_addr] SHALL clear on the edge ending a cycle with regWr = 1; a simultaneous reserve of the same address wins (the bit stays set).
REQ-026 hazA = busy[Rs]; hazB = busy[Rt]; both are 0 for address 0.

Reset
REQ-027 On reset assertion, the block SHALL immediately force: regWr = 0, wr_addr = 0, busW = 0, busy = 0, counter = 0, state = PRIO0.
REQ-028 A request accepted in the cycle reset asserts SHALL be discarded; requesters re-present it after reset.

Configuration
REQ-029 With GPR_ARB_BYPASS_EN defined, the block SHALL add outputs byp_hitA and byp_hitB, each 1 bit: byp_hitA = regWr && wr_addr == Rs && Rs != 0 (likewise Rt for byp_hitB); hazA/hazB SHALL be masked to 0 when the corresponding byp_hit is 1.
REQ-030 Without GPR_ARB_BYPASS_EN, byp_hitA/byp_hitB SHALL not exist, and hazards SHALL follow REQ-026 unmasked.

Structure
REQ-031 Package gpr_arb_pkg SHALL hold: REG_ADDR_W = 5, DATA_W = 32, the state enum (PRIO0, FORCE1), and the default STARVE_LIMIT.
REQ-032 The busy mask plus hazard lookup SHALL be sub-module gpr_scoreboard; arbitration and the write register stay in the top module.

Verification
REQ-033 Reset, then req0 addr 4 data 80 -> next cycle regWr = 1, wr_addr = 4, busW = 80.
REQ-034 Both requesters valid continuously (req0 addr 3 data 111, req1 addr 5 data 7), STARVE_LIMIT = 4 -> req1 accepted on the 5th cycle, then PRIO0 resumes.
REQ-035 req1 alone, addr 0 data 9 -> req1_ready = 1 and regWr stays 0 the next cycle.
REQ-036 Reserve r4; Rs = 4 -> hazA = 1; write r4 granted -> hazA = 0 after the regWr cycle (with the macro: 0 during the regWr cycle and byp_hitA = 1).
REQ-037 rsv_en on r6 in the same cycle regWr writes r6 -> busy[6] stays 1 and hazB = 1 for Rt = 6.
REQ-038 Reset asserted mid-run with regWr = 1 and busy nonzero -> regWr, busy, and outputs zero immediately without waiting for a clock edge.
